// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide add streamed through an external 4-bit adder.
// Sequences operand nibbles LSB first and chains carry between slices.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start              request, sampled in IDLE or DONE
//   op_a, op_b, cin    operands and carry-in, latched on accepted start
//   busy, done         busy while streaming; done pulses for one cycle
//   result             W-bit sum, updated on completion only
//   carry_out          carry out of bit W-1
//   overflow           signed overflow of the wide add
//   add_a/add_b/add_cin  nibble operands driven to the 4-bit adder
//   add_sum/add_cout   4-bit adder response (cout[3] = out, cout[2] = into b3)
module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_cin,
    input  logic [3:0]   add_sum,
    input  logic [3:0]   add_cout
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  shadow;
    logic [W-1:0]  sh_next;
    logic          carry_q;

    // Only the nibble carry-out and the carry into bit 3 matter here.
    logic          unused_cout;
    assign unused_cout = ^add_cout[1:0];

    // Shadow with the current adder nibble merged in, so the final
    // slice is visible in the same edge that publishes the result.
    always_comb begin
        sh_next = shadow;
        sh_next[{idx, 2'b00} +: 4] = add_sum;
    end

    // The adder is combinational: present the current slice directly.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_q[{idx, 2'b00} +: 4];
            add_b   = b_q[{idx, 2'b00} +: 4];
            add_cin = carry_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            shadow    <= '0;
            carry_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        carry_q <= cin;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    shadow  <= sh_next;
                    carry_q <= add_cout[3];
                    if (idx == LAST) begin
                        result    <= sh_next;
                        carry_out <= add_cout[3];
                        overflow  <= add_cout[2] ^ add_cout[3];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed checks of the nibble serial adder
// with a behavioural 4-bit adder closing the loop.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;
    logic        overflow;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic [3:0]  add_cout;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ripple model of the 4-bit adder; cout[i] is the carry out of bit i.
    always_comb begin
        logic c;
        add_sum  = '0;
        add_cout = '0;
        c = add_cin;
        for (int i = 0; i < 4; i++) begin
            add_sum[i]  = add_a[i] ^ add_b[i] ^ c;
            add_cout[i] = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
            c = add_cout[i];
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic ci,
                          input logic [15:0] er, input logic eco,
                          input logic eov);
        int lat;
        logic [15:0] seq;
        logic hit;
        logic ovl;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        cin   = ~ci;
        chk({tag, "_cin0"}, 32'(add_cin), 32'(ci));
        seq = '0;
        hit = 1'b0;
        ovl = 1'b0;
        lat = 1;
        for (int k = 0; k < 20; k++) begin
            if (busy && done) ovl = 1'b1;
            if (done) begin
                hit = 1'b1;
                break;
            end
            if (busy && lat <= 4) seq[(lat-1)*4 +: 4] = add_a;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done"}, 32'(hit), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'd5);
        chk({tag, "_aseq"}, 32'(seq), 32'(a));
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_co"}, 32'(carry_out), 32'(eco));
        chk({tag, "_ov"}, 32'(overflow), 32'(eov));
        chk({tag, "_ovl"}, 32'(ovl), 32'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        int lat;
        int nd;
        int d1;
        int d2;
        logic [15:0] r1;
        logic [15:0] r2;

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", 32'(result), 32'd0);
        chk("rst_co", 32'(carry_out), 32'd0);
        chk("rst_ov", 32'(overflow), 32'd0);
        chk("rst_adda", 32'({add_a, add_b, add_cin}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

        // cin only, with a start pulse mid-run that must be ignored
        @(negedge clk);
        op_a  = 16'h0000;
        op_b  = 16'h0000;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op_a  = 16'hFFFF;
        op_b  = 16'h0001;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        r1 = '0;
        for (int k = 0; k < 15; k++) begin
            if (done) begin
                nd++;
                r1 = result;
            end
            @(negedge clk);
        end
        chk("ign_ndone", 32'(nd), 32'd1);
        chk("ign_res", 32'(r1), 32'h0001);
        chk("ign_hold", 32'(result), 32'h0001);

        // start held high: back-to-back operations
        @(negedge clk);
        op_a  = 16'h0F0F;
        op_b  = 16'h00F1;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        op_a = 16'hABCD;
        op_b = 16'h1234;
        lat = 1;
        d1 = 0;
        d2 = 0;
        r1 = '0;
        r2 = '0;
        for (int k = 0; k < 25; k++) begin
            if (done) begin
                if (d1 == 0) begin
                    d1 = lat;
                    r1 = result;
                end else begin
                    d2 = lat;
                    r2 = result;
                    start = 1'b0;
                    break;
                end
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("b2b_d1", 32'(d1), 32'd5);
        chk("b2b_gap", 32'(d2 - d1), 32'd5);
        chk("b2b_r1", 32'(r1), 32'h1000);
        chk("b2b_r2", 32'(r2), 32'hBE01);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_idle", 32'({busy, done}), 32'd0);

        run_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("all1", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // reset during the third RUN cycle
        @(negedge clk);
        op_a  = 16'h1234;
        op_b  = 16'h1111;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_res", 32'(result), 32'd0);
        chk("mr_flags", 32'({carry_out, overflow}), 32'd0);
        chk("mr_add", 32'({add_a, add_b, add_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            if (done || busy) nd++;
            @(negedge clk);
        end
        chk("mr_quiet", 32'(nd), 32'd0);
        run_op("after", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
